// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite encodings, master FSM state type and a size helper.
package ahb_lite_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StBurst,
    StLast,
    StErr2
  } state_t;

  // Bytes moved per beat for an HSIZE encoding.
  function automatic logic [31:0] size_bytes(input logic [2:0] size);
    return 32'd1 << size;
  endfunction

endpackage

// File: rtl/ahb_addr_gen.sv
// Beat counter and address incrementer; its address register drives HADDR directly.
module ahb_addr_gen
  import ahb_lite_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] load_addr,
  input  logic [2:0]  size,
  output logic [31:0] addr,
  output logic [1:0]  beat
);

  logic [31:0] addr_q;
  logic [1:0]  beat_q;

  // Load on command accept, advance one beat per completed address phase.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q <= 32'd0;
      beat_q <= 2'd0;
    end else if (load) begin
      addr_q <= load_addr;
      beat_q <= 2'd0;
    end else if (step) begin
      addr_q <= addr_q + size_bytes(size);
      beat_q <= beat_q + 2'd1;
    end
  end

  assign addr = addr_q;
  assign beat = beat_q;

endmodule

// File: rtl/ahb_lite_master.sv
// AHB-Lite master: turns one command into a SINGLE or INCR4 transfer with registered bus outputs.
// Define AHB_LITE_MASTER_INCR4_EN to enable INCR4 bursts; otherwise every command is SINGLE.
module ahb_lite_master
  import ahb_lite_pkg::*;
#(
  parameter logic [3:0] HPROT_VAL = 4'b0011,
  parameter logic [1:0] HSEL_VAL  = 2'b01
) (
  input  logic         HCLK,
  input  logic         HRESET,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic         cmd_write,
  input  logic [31:0]  cmd_addr,
  input  logic [2:0]   cmd_size,
  input  logic         cmd_incr4,
  input  logic [127:0] cmd_wdata,
  output logic         rd_valid,
  output logic [31:0]  rd_data,
  output logic         rd_err,
  output logic         cmd_done,
  output logic         cmd_err,
  output logic [31:0]  HADDR,
  output logic [31:0]  HWDATA,
  output logic [1:0]   HTRANS,
  output logic [2:0]   HBURST,
  output logic [2:0]   HSIZE,
  output logic [3:0]   HPROT,
  output logic [1:0]   HSEL,
  output logic         HWRITE,
  input  logic [31:0]  HRDATA,
  input  logic         HREADY,
  input  logic         HRESP
);

  state_t         state_q, state_d;
  logic [1:0]     htrans_q, htrans_d, hsel_q, hsel_d, last_beat_q, last_beat_d;
  logic [2:0]     hburst_q, hburst_d, hsize_q, hsize_d;
  logic           hwrite_q, hwrite_d;
  logic [31:0]    hwdata_q, hwdata_d, rd_data_q, rd_data_d;
  logic [127:0]   wdata_q, wdata_d;
  logic           rd_valid_q, rd_valid_d, rd_err_q, rd_err_d, done_q, done_d, err_q, err_d;
  logic           load, step;
  logic [1:0]     beat;
  logic [31:0]    cmd_bytes;
  logic           incr4_sel, cross_1k, cmd_bad;

  assign cmd_bytes = size_bytes(cmd_size);

`ifdef AHB_LITE_MASTER_INCR4_EN
  assign incr4_sel = cmd_incr4;
  // An INCR4 must stay inside one 1 KB region.
  assign cross_1k  = cmd_incr4 &&
                     (({22'd0, cmd_addr[9:0]} + {cmd_bytes[29:0], 2'b00}) > 32'd1024);
`else
  assign incr4_sel = cmd_incr4 & 1'b0;
  assign cross_1k  = 1'b0;
`endif

  assign cmd_bad = (cmd_size > HSIZE_WORD) || ((cmd_addr & (cmd_bytes - 32'd1)) != 32'd0) ||
                   cross_1k;

  ahb_addr_gen u_addr_gen (
    .clk       (HCLK),
    .rst_n     (HRESET),
    .load      (load),
    .step      (step),
    .load_addr (cmd_addr),
    .size      (hsize_q),
    .addr      (HADDR),
    .beat      (beat)
  );

  // Next-state and registered-output decode; everything holds while HREADY is low.
  always_comb begin
    state_d     = state_q;
    htrans_d    = htrans_q;
    hsel_d      = hsel_q;
    hburst_d    = hburst_q;
    hsize_d     = hsize_q;
    hwrite_d    = hwrite_q;
    hwdata_d    = hwdata_q;
    wdata_d     = wdata_q;
    last_beat_d = last_beat_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    rd_err_d    = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    load        = 1'b0;
    step        = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          if (cmd_bad) begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end else begin
            load        = 1'b1;
            state_d     = StAddr;
            htrans_d    = HTRANS_NONSEQ;
            hsel_d      = HSEL_VAL;
            hburst_d    = incr4_sel ? HBURST_INCR4 : HBURST_SINGLE;
            hsize_d     = cmd_size;
            hwrite_d    = cmd_write;
            wdata_d     = cmd_wdata;
            last_beat_d = incr4_sel ? 2'd3 : 2'd0;
          end
        end
      end
      StAddr, StBurst: begin
        // In StBurst a data phase of the previous beat overlaps the current address phase.
        if (state_q == StBurst && HRESP && !HREADY) begin
          htrans_d = HTRANS_IDLE;
          state_d  = StErr2;
        end else if (HREADY) begin
          if (state_q == StBurst && !hwrite_q) begin
            rd_valid_d = 1'b1;
            rd_data_d  = HRDATA;
            rd_err_d   = HRESP;
          end
          if (state_q == StBurst && HRESP) begin
            done_d   = 1'b1;
            err_d    = 1'b1;
            htrans_d = HTRANS_IDLE;
            hsel_d   = 2'b00;
            state_d  = StIdle;
          end else begin
            hwdata_d = wdata_q[{beat, 5'd0} +: 32];
            if (beat == last_beat_q) begin
              htrans_d = HTRANS_IDLE;
              state_d  = StLast;
            end else begin
              step     = 1'b1;
              htrans_d = HTRANS_SEQ;
              state_d  = StBurst;
            end
          end
        end
      end
      StLast: begin
        if (HRESP && !HREADY) begin
          state_d = StErr2;
        end else if (HREADY) begin
          if (!hwrite_q) begin
            rd_valid_d = 1'b1;
            rd_data_d  = HRDATA;
            rd_err_d   = HRESP;
          end
          done_d  = 1'b1;
          err_d   = HRESP;
          hsel_d  = 2'b00;
          state_d = StIdle;
        end
      end
      StErr2: begin
        if (HREADY) begin
          if (!hwrite_q) begin
            rd_valid_d = 1'b1;
            rd_data_d  = HRDATA;
            rd_err_d   = 1'b1;
          end
          done_d   = 1'b1;
          err_d    = 1'b1;
          htrans_d = HTRANS_IDLE;
          hsel_d   = 2'b00;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge HCLK) begin
    if (!HRESET) begin
      state_q     <= StIdle;
      htrans_q    <= HTRANS_IDLE;
      hsel_q      <= 2'b00;
      hburst_q    <= HBURST_SINGLE;
      hsize_q     <= 3'b000;
      hwrite_q    <= 1'b0;
      hwdata_q    <= 32'd0;
      wdata_q     <= 128'd0;
      last_beat_q <= 2'd0;
      rd_data_q   <= 32'd0;
      rd_valid_q  <= 1'b0;
      rd_err_q    <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      htrans_q    <= htrans_d;
      hsel_q      <= hsel_d;
      hburst_q    <= hburst_d;
      hsize_q     <= hsize_d;
      hwrite_q    <= hwrite_d;
      hwdata_q    <= hwdata_d;
      wdata_q     <= wdata_d;
      last_beat_q <= last_beat_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      rd_err_q    <= rd_err_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign cmd_ready = (state_q == StIdle);
  assign HTRANS    = htrans_q;
  assign HSEL      = hsel_q;
  assign HBURST    = hburst_q;
  assign HSIZE     = hsize_q;
  assign HWRITE    = hwrite_q;
  assign HWDATA    = hwdata_q;
  assign HPROT     = HPROT_VAL;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign rd_err    = rd_err_q;
  assign cmd_done  = done_q;
  assign cmd_err   = err_q;

endmodule

// File: tb/tb_ahb_lite_master.sv
// Bench for ahb_lite_master: table of commands (directed + random) against a transaction-level
// model, with a responsive slave that inserts wait states and two-cycle error responses.
module tb_ahb_lite_master;
  import ahb_lite_pkg::*;

`ifdef AHB_LITE_MASTER_INCR4_EN
  localparam bit IncrEn = 1'b1;
`else
  localparam bit IncrEn = 1'b0;
`endif

  localparam int NDir  = 11;
  localparam int NRand = 30;
  localparam int NoBeat = 9;

  logic         HCLK = 1'b0;
  logic         HRESET;
  logic         cmd_valid, cmd_ready, cmd_write, cmd_incr4;
  logic [31:0]  cmd_addr;
  logic [2:0]   cmd_size;
  logic [127:0] cmd_wdata;
  logic         rd_valid, rd_err, cmd_done, cmd_err;
  logic [31:0]  rd_data;
  logic [31:0]  HADDR, HWDATA, HRDATA;
  logic [1:0]   HTRANS, HSEL;
  logic [2:0]   HBURST, HSIZE;
  logic [3:0]   HPROT;
  logic         HWRITE, HREADY, HRESP;

  ahb_lite_master dut (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_size  (cmd_size),
    .cmd_incr4 (cmd_incr4),
    .cmd_wdata (cmd_wdata),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .rd_err    (rd_err),
    .cmd_done  (cmd_done),
    .cmd_err   (cmd_err),
    .HADDR     (HADDR),
    .HWDATA    (HWDATA),
    .HTRANS    (HTRANS),
    .HBURST    (HBURST),
    .HSIZE     (HSIZE),
    .HPROT     (HPROT),
    .HSEL      (HSEL),
    .HWRITE    (HWRITE),
    .HRDATA    (HRDATA),
    .HREADY    (HREADY),
    .HRESP     (HRESP)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    bit           wr;
    logic [31:0]  addr;
    logic [2:0]   size;
    bit           incr4;
    logic [127:0] wdata;
    logic [31:0]  rbase;      // read beat i returns rbase + i
    int           stall_beat; // data phase that gets stall_n wait states
    int           stall_n;
    int           err_beat;   // data phase answered with a two-cycle error
    int           exp_beats;  // address phases that must complete
    bit           exp_err;
    int           exp_lat;    // cycles from accept edge to cmd_done
  } vec_t;

  vec_t vecs [NDir + NRand];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Outcome of a command from the protocol rules alone.
  function automatic vec_t model(input vec_t v);
    vec_t r;
    int   bytes, n, stalls;
    bit   rej;
    r     = v;
    bytes = 1 << v.size;
    n     = (IncrEn && v.incr4) ? 4 : 1;
    rej   = (v.size > 3'd2) || ((v.addr & 32'(bytes - 1)) != 32'd0) ||
            (n == 4 && int'(v.addr[9:0]) + 4 * bytes > 1024);
    if (rej) begin
      r.exp_beats = 0;
      r.exp_err   = 1'b1;
      r.exp_lat   = 1;
    end else begin
      r.exp_err   = v.err_beat < n;
      r.exp_beats = r.exp_err ? v.err_beat + 1 : n;
      stalls      = (v.stall_beat < r.exp_beats && v.stall_beat != v.err_beat) ? v.stall_n : 0;
      r.exp_lat   = r.exp_beats + 2 + stalls + (r.exp_err ? 1 : 0);
    end
    return r;
  endfunction

  function automatic vec_t mk(input bit wr, input logic [31:0] addr, input logic [2:0] size,
                              input bit incr4, input logic [127:0] wdata,
                              input logic [31:0] rbase, input int sb, input int sn,
                              input int eb);
    vec_t v;
    v.wr = wr; v.addr = addr; v.size = size; v.incr4 = incr4; v.wdata = wdata;
    v.rbase = rbase; v.stall_beat = sb; v.stall_n = sn; v.err_beat = eb;
    v.exp_beats = 0; v.exp_err = 1'b0; v.exp_lat = 0;
    return model(v);
  endfunction

  // Issue one command at a negedge and act as the slave until cmd_done (bounded).
  task automatic run_vec(input vec_t v);
    int          cyc, ac, rd_cnt, dp_beat, stall_left, err_stage;
    bit          dp, done_seen, hold;
    logic [31:0] h_addr, h_wdata, bytes;
    logic [1:0]  h_trans;
    logic [2:0]  exp_burst;
    bytes      = 32'd1 << v.size;
    exp_burst  = (IncrEn && v.incr4) ? HBURST_INCR4 : HBURST_SINGLE;
    ac = 0; rd_cnt = 0; dp = 1'b0; dp_beat = 0; stall_left = v.stall_n; err_stage = 0;
    done_seen = 1'b0; hold = 1'b0; h_addr = '0; h_wdata = '0; h_trans = '0;
    chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_write = v.wr; cmd_addr = v.addr; cmd_size = v.size;
    cmd_incr4 = v.incr4; cmd_wdata = v.wdata; HREADY = 1'b1; HRESP = 1'b0;
    @(negedge HCLK);
    cmd_valid = 1'b0;
    cyc = 1;
    while (!done_seen && cyc <= 40) begin
      if (rd_valid) begin
        if (!v.wr) begin
          chk("rd_data", rd_data, v.rbase + 32'(rd_cnt));
          chk("rd_err", 32'(rd_err), 32'(v.exp_err && rd_cnt == v.exp_beats - 1));
        end
        rd_cnt++;
      end
      if (cmd_done) begin
        chk("done_latency", 32'(cyc), 32'(v.exp_lat));
        chk("cmd_err", 32'(cmd_err), 32'(v.exp_err));
        done_seen = 1'b1;
      end
      if (hold) begin
        chk("hold_haddr", HADDR, h_addr);
        chk("hold_htrans", 32'(HTRANS), 32'(h_trans));
        chk("hold_hwdata", HWDATA, h_wdata);
        hold = 1'b0;
      end
      HREADY = 1'b1; HRESP = 1'b0; HRDATA = $urandom;
      if (dp) begin
        HRDATA = v.rbase + 32'(dp_beat);
        if (dp_beat == v.err_beat) begin
          if (err_stage == 0) begin
            HREADY = 1'b0; HRESP = 1'b1; err_stage = 1;
          end else begin
            chk("err2_htrans_idle", 32'(HTRANS), 32'(HTRANS_IDLE));
            HRESP = 1'b1;
          end
        end else if (dp_beat == v.stall_beat && stall_left > 0) begin
          HREADY = 1'b0;
          stall_left--;
        end
      end
      if (!HREADY && !HRESP) begin
        hold = 1'b1; h_addr = HADDR; h_trans = HTRANS; h_wdata = HWDATA;
      end
      if (dp && HREADY) begin
        if (v.wr) chk("hwdata", HWDATA, v.wdata[32*dp_beat +: 32]);
        dp = 1'b0;
      end
      if (HTRANS[1] && HREADY && !HRESP) begin
        chk("haddr", HADDR, v.addr + 32'(ac) * bytes);
        chk("htrans", 32'(HTRANS), 32'(ac == 0 ? HTRANS_NONSEQ : HTRANS_SEQ));
        chk("hburst", 32'(HBURST), 32'(exp_burst));
        chk("hsize", 32'(HSIZE), 32'(v.size));
        chk("hwrite", 32'(HWRITE), 32'(v.wr));
        chk("hsel", 32'(HSEL), 32'(2'b01));
        chk("hprot", 32'(HPROT), 32'(4'b0011));
        dp = 1'b1; dp_beat = ac; ac++;
      end
      @(negedge HCLK);
      cyc++;
    end
    chk("done_seen", 32'(done_seen), 32'd1);
    chk("addr_phases", 32'(ac), 32'(v.exp_beats));
    chk("rd_pulses", 32'(rd_cnt), v.wr ? 32'd0 : 32'(v.exp_beats));
    chk("done_is_pulse", 32'(cmd_done), 32'd0);
    chk("post_htrans", 32'(HTRANS), 32'(HTRANS_IDLE));
    chk("post_hsel", 32'(HSEL), 32'd0);
  endtask

  initial begin
    logic [31:0] a;
    logic [2:0]  s;
    int          pulses;
    HRESET = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_size = '0;
    cmd_incr4 = 1'b0; cmd_wdata = '0; HRDATA = '0; HREADY = 1'b1; HRESP = 1'b0;

    vecs[0]  = mk(1, 32'h100, 3'd2, 0, 128'hDEADBEEF, 32'd0, NoBeat, 0, NoBeat);
    vecs[1]  = mk(0, 32'h200, 3'd2, 1, 128'd0, 32'd1, NoBeat, 0, NoBeat);
    vecs[2]  = mk(1, 32'h300, 3'd2, 1, 128'h44444444_33333333_22222222_11111111, 32'd0,
                  1, 2, NoBeat);
    vecs[3]  = mk(0, 32'h080, 3'd2, 1, 128'd0, 32'hA0, NoBeat, 0, 1);
    vecs[4]  = mk(1, 32'h3F8, 3'd2, 1, 128'h5, 32'd0, NoBeat, 0, NoBeat);
    vecs[5]  = mk(0, 32'h101, 3'd1, 0, 128'd0, 32'd0, NoBeat, 0, NoBeat);
    vecs[6]  = mk(0, 32'h100, 3'd3, 0, 128'd0, 32'd0, NoBeat, 0, NoBeat);
    vecs[7]  = mk(0, 32'h3F0, 3'd2, 1, 128'd0, 32'h77, 0, 1, NoBeat);
    vecs[8]  = mk(1, 32'h011, 3'd0, 1, 128'hAA_BB_CC_DD, 32'd0, 3, 1, NoBeat);
    vecs[9]  = mk(0, 32'h040, 3'd2, 0, 128'd0, 32'h55, NoBeat, 0, 0);
    vecs[10] = mk(1, 32'h3FC, 3'd1, 1, 128'd0, 32'd0, NoBeat, 0, NoBeat);
    for (int i = NDir; i < NDir + NRand; i++) begin
      s = 3'($urandom % 4);
      a = $urandom;
      if ($urandom % 3 == 0) a[9:0] = 10'h3C0 | 10'($urandom % 64);
      if ($urandom % 4 != 0) a = a & ~((32'd1 << s) - 32'd1);
      vecs[i] = mk(bit'($urandom % 2), a, s, bit'($urandom % 2),
                   {$urandom, $urandom, $urandom, $urandom}, $urandom,
                   int'($urandom % 4), int'($urandom_range(3, 0)),
                   ($urandom % 4 == 0) ? int'($urandom % 4) : NoBeat);
    end

    repeat (3) @(negedge HCLK);
    chk("rst_htrans", 32'(HTRANS), 32'(HTRANS_IDLE));
    chk("rst_haddr", HADDR, 32'd0);
    chk("rst_hwdata", HWDATA, 32'd0);
    chk("rst_hsize", 32'(HSIZE), 32'd0);
    chk("rst_hburst", 32'(HBURST), 32'd0);
    chk("rst_hwrite", 32'(HWRITE), 32'd0);
    chk("rst_hsel", 32'(HSEL), 32'd0);
    chk("rst_hprot", 32'(HPROT), 32'(4'b0011));
    chk("rst_flags", {28'd0, rd_valid, rd_err, cmd_done, cmd_err}, 32'd0);
    HRESET = 1'b1;
    @(negedge HCLK);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);

    for (int i = 0; i < NDir + NRand; i++) run_vec(vecs[i]);

    // Reset in the middle of a command abandons it silently.
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h40; cmd_size = 3'd2;
    cmd_incr4 = 1'b1; cmd_wdata = {4{32'hCAFE0000}};
    HREADY = 1'b1; HRESP = 1'b0;
    @(negedge HCLK);
    cmd_valid = 1'b0;
    chk("mid_nonseq", 32'(HTRANS), 32'(HTRANS_NONSEQ));
    @(negedge HCLK);
    HRESET = 1'b0;
    @(negedge HCLK);
    HRESET = 1'b1;
    chk("mid_rst_htrans", 32'(HTRANS), 32'(HTRANS_IDLE));
    chk("mid_rst_hsel", 32'(HSEL), 32'd0);
    chk("mid_rst_haddr", HADDR, 32'd0);
    chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge HCLK);
      if (cmd_done || HTRANS != HTRANS_IDLE) pulses++;
    end
    chk("mid_rst_no_activity", 32'(pulses), 32'd0);
    chk("mid_rst_ready_after", 32'(cmd_ready), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ahb_lite_master.md
AHB_LITE_MASTER -- requirements
Module: ahb_lite_master

Interface
REQ-001 SHALL have parameter HPROT_VAL, default 4'b0011, the constant driven on HPROT (non-cacheable, privileged data).
REQ-002 SHALL have parameter HSEL_VAL, default 2'b01, the constant driven on HSEL while a transfer is in progress; 2'b00 otherwise.
REQ-003 SHALL have one clock; reset is synchronous and active-low.
REQ-004 Ports:
- HCLK  in  1  bus clock, rising edge.
- HRESET  in  1  synchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  32  start address.
- cmd_size  in  3  HSIZE encoding.
- cmd_incr4  in  1  1 = INCR4 burst, 0 = SINGLE.
- cmd_wdata  in  128  write beats; beat i uses bits [32i+31:32i].
- rd_valid  out  1  one-cycle pulse per completed read beat.
- rd_data  out  32  read beat data.
- rd_err  out  1  beat ended with HRESP=1.
- cmd_done  out  1  one-cycle pulse, command finished.
- cmd_err  out  1  qualifies cmd_done: error or rejected.
- HADDR, HWDATA  out  32  AHB address and write data.
- HTRANS  out  2; HBURST, HSIZE  out  3; HPROT  out  4; HSEL  out  2; HWRITE  out  1.
- HRDATA  in  32; HREADY, HRESP  in  1  from the slave/mux.

Function
REQ-005 SHALL register all AHB outputs; there is no combinational path from any input to any output.
REQ-006 States: IDLE, ADDR (first-beat address phase, NONSEQ), BURST (SEQ address and overlapped data phase), LAST (final data phase only), ERR2 (second HRESP cycle).
REQ-007 cmd_ready SHALL be 1 only in IDLE; on accept, the next cycle drives HTRANS=NONSEQ with HADDR=cmd_addr, HBURST=INCR4 or SINGLE, and HSIZE/HWRITE from the command.
REQ-008 An address or data phase SHALL advance only on a rising edge with HREADY=1; all AHB outputs are held stable while HREADY=0.
REQ-009 Beat address SHALL be prior HADDR + (1<<cmd_size), 32-bit wrap; beats 2..4 use HTRANS=SEQ.
REQ-010 HWDATA for beat i SHALL be driven during that beat's data phase (one cycle after its address phase completes).
REQ-011 Read data SHALL be sampled on the data-phase edge with HREADY=1; rd_valid pulses the next cycle with rd_data and rd_err.
REQ-012 After the last address phase, HTRANS=IDLE; cmd_done pulses the cycle after the last data phase completes; FSM returns to IDLE on that same edge.
REQ-013 A command SHALL be rejected (cmd_done=1, cmd_err=1 the next cycle, no bus activity) when cmd_size>3'b010, the address is unaligned to the size, or an INCR4 would cross a 1 KB boundary.
REQ-014 Error response: on HRESP=1 with HREADY=0, the next cycle SHALL drive HTRANS=IDLE (cancelling pending SEQ beats) and enter ERR2; on HRESP=1 with HREADY=1, cmd_done and cmd_err pulse and the remaining beats are not issued.
REQ-015 A read beat that errors SHALL still produce rd_valid with rd_err=1.

Reset
REQ-016 With HRESET=0 at a clock edge, the FSM SHALL enter IDLE and these outputs are reset: HTRANS=IDLE; HADDR, HWDATA, HSIZE, HBURST, HWRITE, HSEL all 0; HPROT=HPROT_VAL; cmd_ready=1 from the first cycle after release; rd_valid, cmd_done, cmd_err, rd_err all 0.
REQ-017 Reset mid-burst SHALL abandon the command without cmd_done.

Configuration
REQ-018 Macro AHB_LITE_MASTER_INCR4_EN: when defined, INCR4 is supported as above; when undefined, cmd_incr4 is ignored, every command is SINGLE (HBURST=3'b000), and the 1 KB check is removed.

Structure
REQ-019 Package ahb_lite_pkg SHALL hold the HTRANS_* constants (IDLE=2'b00, BUSY=2'b01, NONSEQ=2'b10, SEQ=2'b11), the HBURST_SINGLE/HBURST_INCR4 and HSIZE_* constants, and the master state enum.
REQ-020 The beat counter and address incrementer SHALL be sub-module ahb_addr_gen; everything else is in ahb_lite_master.

Verification
REQ-021 Single write, addr 0x100, size 2, data 0xDEADBEEF, HREADY=1 -> NONSEQ at cycle 1, HWDATA=0xDEADBEEF at cycle 2, cmd_done at cycle 3, cmd_err=0.
REQ-022 INCR4 read at 0x200, size 2, HRDATA 1..4 -> HADDR 0x200/0x204/0x208/0x20C, NONSEQ then 3 SEQ, 4 rd_valid pulses with data 1..4.
REQ-023 INCR4 write with HREADY=0 for 2 cycles on beat 2 -> HADDR, HTRANS and HWDATA held; all 4 beats complete in order.
REQ-024 Two-cycle HRESP error on beat 2 of an INCR4 read -> HTRANS=IDLE in the second error cycle, beats 3-4 are not issued, rd_err=1, cmd_done with cmd_err=1.
REQ-025 INCR4 at 0x3F8, size 2 -> rejected: no NONSEQ issued, cmd_done with cmd_err=1; HRESET=0 during a burst -> HTRANS=IDLE and cmd_ready=1 after release.
